// File: rtl/wos_pkg.sv
// Shared types for the weighted-order-statistics demo:
// batch FSM states and default datapath widths.
package wos_pkg;

  localparam int DATA_BITS_DEF = 8;
  localparam int ADDR_BITS_DEF = 8;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    STREAM,
    FLUSH,
    DONE
  } wos_state_e;

endpackage

// File: rtl/wos_wrap_counter.sv
// Up/down pulse counter wrapping modulo N.
// Opposing pulses in the same cycle cancel.
module wos_wrap_counter #(
  parameter int W = 8,
  parameter int N = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         up,
  input  logic         down,
  output logic [W-1:0] value
);

  localparam logic [W-1:0] MAX = W'(N - 1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (en && (up ^ down)) begin
      if (up)
        value <= (value == MAX) ? '0 : value + 1'b1;
      else
        value <= (value == '0) ? MAX : value - 1'b1;
    end
  end

endmodule

// File: rtl/wos_batch_sequencer.sv
// Batch controller: streams ROM samples through the
// rank filter, flushes it and stores every result.
import wos_pkg::*;

module wos_batch_sequencer #(
  parameter int DATA_BITS   = DATA_BITS_DEF,
  parameter int ADDR_BITS   = ADDR_BITS_DEF,
  parameter int NUM_SAMPLES = 255,
  parameter int FILTER_LAT  = 1,
  parameter logic [DATA_BITS-1:0] PAD_VALUE = '0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic                 key_up,
  input  logic                 key_down,
  output logic [ADDR_BITS-1:0] rom_addr,
  input  logic [DATA_BITS-1:0] rom_data,
  output logic                 filt_en,
  output logic [DATA_BITS-1:0] filt_in,
  input  logic [DATA_BITS-1:0] filt_out,
  output logic                 ram_we,
  output logic [ADDR_BITS-1:0] ram_waddr,
  output logic [DATA_BITS-1:0] ram_wdata,
  output logic [ADDR_BITS-1:0] view_addr,
  output logic                 busy,
  output logic                 done
);

  localparam int CW = ADDR_BITS + 4;
  localparam logic [CW-1:0] LAST_S = CW'(NUM_SAMPLES - 1);
  localparam logic [CW-1:0] LAST_F =
    CW'(NUM_SAMPLES + FILTER_LAT - 1);
  localparam logic [CW-1:0] LAT_C = CW'(FILTER_LAT);

  wos_state_e    state;
  logic [CW-1:0] n;
  logic          armed;
  logic [2:0]    key_now;
  logic [2:0]    key_p;
  logic [2:0]    pulse;
  logic          lat_ok;
  logic          browse;

  assign key_now = {start, key_up, key_down};
  assign pulse   = armed ? (key_now & ~key_p) : 3'b000;

  // First clock after reset only samples the keys, so a key
  // held through reset produces no pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      armed <= 1'b0;
      key_p <= 3'b000;
    end else begin
      armed <= 1'b1;
      key_p <= key_now;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      rom_addr <= '0;
      n        <= '0;
      filt_en  <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      unique case (state)
        IDLE, DONE: begin
          if (pulse[2]) begin
            state    <= PRIME;
            rom_addr <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
          end
        end
        PRIME: begin
          state    <= STREAM;
          rom_addr <= rom_addr + 1'b1;
          n        <= '0;
          filt_en  <= 1'b1;
        end
        STREAM: begin
          rom_addr <= rom_addr + 1'b1;
          n        <= n + 1'b1;
          if (n == LAST_S) begin
            if (FILTER_LAT == 0) begin
              state   <= DONE;
              filt_en <= 1'b0;
              busy    <= 1'b0;
              done    <= 1'b1;
            end else begin
              state <= FLUSH;
            end
          end
        end
        FLUSH: begin
          n <= n + 1'b1;
          if (n == LAST_F) begin
            state   <= DONE;
            filt_en <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b1;
          end
        end
        default: begin
          state   <= IDLE;
          filt_en <= 1'b0;
          busy    <= 1'b0;
          done    <= 1'b0;
        end
      endcase
    end
  end

  generate
    if (FILTER_LAT == 0) begin : g_nolat
      assign lat_ok = 1'b1;
    end else begin : g_lat
      assign lat_ok = (n >= LAT_C);
    end
  endgenerate

  // Results lag their samples by FILTER_LAT enables.
  assign ram_we    = filt_en & lat_ok;
  assign ram_waddr = ram_we ? ADDR_BITS'(n - LAT_C) : '0;
  assign ram_wdata = ram_we ? filt_out : '0;

  always_comb begin
    filt_in = '0;
    if (filt_en)
      filt_in = (state == FLUSH) ? PAD_VALUE : rom_data;
  end

  assign browse = (state == IDLE) || (state == DONE);

  wos_wrap_counter #(
    .W (ADDR_BITS),
    .N (NUM_SAMPLES)
  ) u_view (
    .clk   (clk),
    .rst   (rst),
    .en    (browse),
    .up    (pulse[1]),
    .down  (pulse[0]),
    .value (view_addr)
  );

endmodule

// File: tb/tb_wos_batch_sequencer.sv
// Directed bench: 8-sample / 2-latency instance and a
// 256-sample / zero-latency instance.
module tb_wos_batch_sequencer;

  logic clk;
  logic rst;

  logic       a_start, a_up, a_down;
  logic [7:0] a_rom_addr, a_rom_data;
  logic       a_filt_en;
  logic [7:0] a_filt_in, a_filt_out;
  logic       a_we;
  logic [7:0] a_waddr, a_wdata, a_view;
  logic       a_busy, a_done;

  logic       b_start, b_up, b_down;
  logic [7:0] b_rom_addr, b_rom_data;
  logic       b_filt_en;
  logic [7:0] b_filt_in, b_filt_out;
  logic       b_we;
  logic [7:0] b_waddr, b_wdata, b_view;
  logic       b_busy, b_done;

  logic [7:0] a_d1, a_d2;
  logic [7:0] ram_a [0:255];

  int nchk = 0;
  int nerr = 0;

  wos_batch_sequencer #(
    .DATA_BITS(8), .ADDR_BITS(8),
    .NUM_SAMPLES(8), .FILTER_LAT(2),
    .PAD_VALUE(8'd0)
  ) dut_a (
    .clk(clk), .rst(rst),
    .start(a_start), .key_up(a_up), .key_down(a_down),
    .rom_addr(a_rom_addr), .rom_data(a_rom_data),
    .filt_en(a_filt_en), .filt_in(a_filt_in),
    .filt_out(a_filt_out),
    .ram_we(a_we), .ram_waddr(a_waddr),
    .ram_wdata(a_wdata),
    .view_addr(a_view), .busy(a_busy), .done(a_done)
  );

  wos_batch_sequencer #(
    .DATA_BITS(8), .ADDR_BITS(8),
    .NUM_SAMPLES(256), .FILTER_LAT(0),
    .PAD_VALUE(8'd0)
  ) dut_b (
    .clk(clk), .rst(rst),
    .start(b_start), .key_up(b_up), .key_down(b_down),
    .rom_addr(b_rom_addr), .rom_data(b_rom_data),
    .filt_en(b_filt_en), .filt_in(b_filt_in),
    .filt_out(b_filt_out),
    .ram_we(b_we), .ram_waddr(b_waddr),
    .ram_wdata(b_wdata),
    .view_addr(b_view), .busy(b_busy), .done(b_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) a_rom_data <= a_rom_addr + 8'd10;
  always @(posedge clk) b_rom_data <= b_rom_addr + 8'd10;

  always @(posedge clk)
    if (a_filt_en) begin
      a_d1 <= a_filt_in;
      a_d2 <= a_d1;
    end
  assign a_filt_out = a_d2;
  assign b_filt_out = b_filt_in;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic run_a(input int bump_at,
                       output int wr, output int fe,
                       output int pd, output int dc,
                       output int busy1);
    wr = 0; fe = 0; pd = 0; dc = 0; busy1 = 0;
    @(negedge clk);
    a_start = 1'b1;
    for (int c = 1; c <= 40 && dc == 0; c++) begin
      @(posedge clk);
      #1;
      if (a_we) begin
        wr++;
        ram_a[a_waddr] = a_wdata;
      end
      if (a_filt_en) begin
        fe++;
        if (a_filt_in == 8'd0) pd++;
      end
      if (c == 1) busy1 = int'(a_busy);
      if (a_done) dc = c;
      if (c == 3) a_start = 1'b0;
      if (c == bump_at) a_up = 1'b1;
      if (c == bump_at + 1) a_up = 1'b0;
    end
    a_start = 1'b0;
    a_up = 1'b0;
  endtask

  task automatic press_a(input logic up, input logic dn);
    @(negedge clk);
    a_up = up;
    a_down = dn;
    @(negedge clk);
    a_up = 1'b0;
    a_down = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int wr, fe, pd, dc, busy1, bad, wcnt, last;
    logic [7:0] exp_view [0:6];
    exp_view[0] = 8'd7; exp_view[1] = 8'd6;
    exp_view[2] = 8'd5; exp_view[3] = 8'd6;
    exp_view[4] = 8'd7; exp_view[5] = 8'd0;
    exp_view[6] = 8'd1;

    rst = 1'b0;
    a_start = 0; a_up = 0; a_down = 0;
    b_start = 0; b_up = 0; b_down = 0;
    repeat (3) @(negedge clk);
    chk("rst_rom_addr", a_rom_addr, 0);
    chk("rst_view", a_view, 0);
    chk("rst_waddr", a_waddr, 0);
    chk("rst_filt_en", a_filt_en, 0);
    chk("rst_we", a_we, 0);
    chk("rst_busy", a_busy, 0);
    chk("rst_done", a_done, 0);
    rst = 1'b1;

    bad = 0; wcnt = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (a_we) wcnt++;
      if ((a_rom_addr | a_view | a_waddr) != 0) bad++;
      if ((a_filt_en | a_busy | a_done) != 0) bad++;
    end
    chk("idle_outputs", bad, 0);
    chk("idle_no_we", wcnt, 0);

    for (int i = 0; i < 256; i++) ram_a[i] = 8'hff;
    run_a(99, wr, fe, pd, dc, busy1);
    chk("b1_busy", busy1, 1);
    chk("b1_writes", wr, 8);
    chk("b1_filt_en", fe, 10);
    chk("b1_pads", pd, 2);
    chk("b1_done_cycle", dc, 12);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b1_ram%0d", i), ram_a[i], i + 10);

    for (int k = 0; k < 3; k++) begin
      press_a(1'b0, 1'b1);
      chk($sformatf("down%0d", k), a_view, exp_view[k]);
    end
    for (int k = 3; k < 7; k++) begin
      press_a(1'b1, 1'b0);
      chk($sformatf("up%0d", k), a_view, exp_view[k]);
    end
    press_a(1'b1, 1'b1);
    chk("up_down_same", a_view, 1);

    run_a(4, wr, fe, pd, dc, busy1);
    chk("b2_writes", wr, 8);
    chk("b2_done_cycle", dc, 12);
    chk("b2_up_busy", a_view, 1);

    @(negedge clk);
    a_start = 1'b1;
    for (int c = 1; c <= 6; c++) begin
      @(posedge clk);
      #1;
      if (c == 3) a_start = 1'b0;
    end
    a_up = 1'b1;
    rst = 1'b0;
    #1;
    chk("mid_rst_busy", a_busy, 0);
    chk("mid_rst_filt_en", a_filt_en, 0);
    chk("mid_rst_we", a_we, 0);
    chk("mid_rst_rom", a_rom_addr, 0);
    chk("mid_rst_view", a_view, 0);
    wcnt = 0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (a_we) wcnt++;
    end
    chk("no_we_after_rst", wcnt, 0);
    chk("held_key_no_pulse", a_view, 0);
    a_up = 1'b0;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 256; i++) ram_a[i] = 8'hff;
    run_a(99, wr, fe, pd, dc, busy1);
    chk("b3_writes", wr, 8);
    chk("b3_done_cycle", dc, 12);
    for (int i = 0; i < 8; i++)
      chk($sformatf("b3_ram%0d", i), ram_a[i], i + 10);

    wr = 0; fe = 0; dc = 0; last = -1; bad = 0;
    @(negedge clk);
    b_start = 1'b1;
    for (int c = 1; c <= 300 && dc == 0; c++) begin
      @(posedge clk);
      #1;
      if (b_we) begin
        if (int'(b_wdata) != ((wr + 10) % 256)) bad++;
        wr++;
        last = int'(b_waddr);
      end
      if (b_filt_en) fe++;
      if (b_done) dc = c;
      if (c == 3) b_start = 1'b0;
    end
    b_start = 1'b0;
    chk("big_writes", wr, 256);
    chk("big_filt_en", fe, 256);
    chk("big_last_addr", last, 255);
    chk("big_data", bad, 0);
    chk("big_done_cycle", dc, 258);

    @(negedge clk);
    b_down = 1'b1;
    @(negedge clk);
    b_down = 1'b0;
    @(negedge clk);
    chk("big_view_wrap", b_view, 255);

    $display("End of test - %0d assertions evaluated, %0d failures",
             nchk, nerr);
    $finish;
  end

endmodule
